pipe_block_serializer: RTL and testbench
========================================

Name: pipe_block_serializer

Overview:
- Output-side companion to the block DES engine. It accepts 64-bit result blocks from the engine over a valid/ready handshake and buffers them in a small FIFO.
- It serves the buffered data to a 16-bit okPipeOut endpoint, one word per ep_read strobe, as first-word-fall-through.
- It counts drained blocks and pulses done for the TriggerOut when a host-programmed block count has been fully read.
- It replaces the fixed 2048-byte output RAM, so results stream out without a block-RAM round trip.

Parameters:
- DEPTH_LOG2, 3, FIFO depth is 2**DEPTH_LOG2 64-bit blocks.
- CNT_W, 16, width of the drain-target and drained-block counters.

Ports:
- ti_clk  in  1  host interface clock; all logic is synchronous to it.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush, one-cycle pulse (driven from a TriggerIn).
- blk_valid  in  1  engine presents a block.
- blk_ready  out  1  FIFO can accept a block.
- blk_data  in  64  result block; bits [15:0] are word 0.
- pipe_read  in  1  okPipeOut ep_read strobe.
- pipe_data  out  16  okPipeOut ep_datain.
- drain_target  in  CNT_W  number of blocks per transfer; 0 disables done.
- done  out  1  one-cycle pulse to the TriggerOut.
- level  out  DEPTH_LOG2+1  blocks currently stored.
- underflow  out  1  sticky; set by a read while the FIFO is empty.

Behaviour:
- Reset (async assert, sync release via the flop): count=0, word index=0, drained=0, done=0, underflow=0, level=0. blk_ready is 1 in the first cycle after reset. pipe_data=0.
- Storage: register array of 2**DEPTH_LOG2 x 64 bits with wr_ptr/rd_ptr of DEPTH_LOG2 bits. Pointers wrap naturally modulo depth. count is DEPTH_LOG2+1 bits.
- blk_ready = (count != 2**DEPTH_LOG2), decoded combinationally from registered count.
- A push occurs on blk_valid && blk_ready. Data is written at wr_ptr and wr_ptr increments.
- When full, no push occurs even if a pop happens in the same cycle (no bypass).
- pipe_data is a combinational mux of mem[rd_ptr] by word index: idx 0→[15:0], 1→[31:16], 2→[47:32], 3→[63:48]. It is 0 when empty. Data is valid before the strobe (FWFT).
- Read with count>0: idx increments. At idx==3 the read pops: idx→0, rd_ptr+1, count-1.
- Read with count==0: underflow is set, and idx/pointers/count are unchanged.
- Simultaneous push and pop: count is unchanged; both pointers advance.
- drained increments on each pop. If drain_target!=0 and drained+1==drain_target on a pop:
  - done=1 in the next cycle;
  - drained→0.
- done is a registered one-cycle pulse.
- If drain_target changes mid-transfer, the comparison uses the new value. If drained already exceeds the new target, done does not fire until the counter wraps; the host must clear before reprogramming.
- clear has priority over push, pop and read in the same cycle. It sets count=0, pointers=0, idx=0, drained=0, underflow=0 and done=0. A block offered in the clear cycle is dropped; the engine sees blk_ready and must treat that push as accepted-and-discarded. The top level holds the engine in reset during clear.
- level = count, registered.

Decomposition:
- Shared package holds:
  - localparam WORD_W=16, BLOCK_W=64, WORDS_PER_BLOCK=4;
  - IDX_W=2;
  - the word-order function (block, idx → word), so the input-side packer uses the identical ordering.
- One sub-module is natural: sync_fifo_reg (depth/width-parameterised register FIFO with count). The word sequencer and done counter stay in the top.

Test Plan:
- Push one block 64'h0123_4567_89AB_CDEF, then 4 reads → pipe_data CDEF, 89AB, 4567, 0123. After the 4th read, level=0 and pipe_data=0.
- Push 9 blocks back-to-back with DEPTH_LOG2=3 → blk_ready deasserts after the 8th push and the 9th is held. One full block read (4 strobes) → 9th accepted the following cycle; level returns to 8.
- drain_target=2, push 2 blocks, 8 reads → done pulses exactly once, one cycle after the 8th read. drain_target=0 with the same stimulus → no done.
- Read while empty → underflow=1 and stays 1. Pointers are unchanged: a subsequent push plus 4 reads returns the correct words. A clear pulse → underflow=0.
- Full FIFO with a pop and blk_valid in the same cycle → no push that cycle, level=7 next cycle, push accepted the cycle after (level=8).
- Mid-block clear after 2 reads of 3 stored blocks → level=0, idx=0. Next pushed block's word 0 appears first. Assert reset_n=0 mid-transfer → all outputs at reset values asynchronously.

Source files
------------

// File: rtl/pipe_block_serializer_pkg.sv
// Shared word-ordering definitions for the block serializer and the input-side packer.
// Word 0 of a block is its least-significant 16 bits.
package pipe_block_serializer_pkg;

  localparam int WORD_W          = 16;
  localparam int BLOCK_W         = 64;
  localparam int WORDS_PER_BLOCK = 4;
  localparam int IDX_W           = 2;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [BLOCK_W-1:0] block_t;

  function automatic word_t block_word(input block_t blk, input logic [IDX_W-1:0] idx);
    return blk[idx*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/pipe_block_serializer_sync_fifo_reg.sv
// Register-array FIFO with occupancy count and synchronous flush.
// A push while full is dropped even if a pop happens in the same cycle.
module sync_fifo_reg #(
  parameter int DEPTH_LOG2 = 3,
  parameter int WIDTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pipe_block_serializer.sv
// Streams buffered 64-bit result blocks to a 16-bit pipe-out endpoint, word 0 first,
// and pulses done once the programmed number of blocks has been fully read.
module pipe_block_serializer
  import pipe_block_serializer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  ti_clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  blk_valid,
  output logic                  blk_ready,
  input  logic [63:0]           blk_data,
  input  logic                  pipe_read,
  output logic [15:0]           pipe_data,
  input  logic [CNT_W-1:0]      drain_target,
  output logic                  done,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  underflow
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

  block_t              head;
  logic [DEPTH_LOG2:0] count;
  logic                full;
  logic                empty;
  logic [IDX_W-1:0]    idx;
  logic [CNT_W-1:0]    drained;
  logic [CNT_W-1:0]    drained_inc;
  logic                rd_ok;
  logic                pop;
  logic                target_hit;

  sync_fifo_reg #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (BLOCK_W)
  ) u_fifo (
    .clk     (ti_clk),
    .rst_n   (reset_n),
    .clear   (clear),
    .push    (blk_valid),
    .wr_data (blk_data),
    .pop     (pop),
    .rd_data (head),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  assign blk_ready   = !full;
  assign level       = count;
  assign pipe_data   = empty ? '0 : block_word(head, idx);
  assign rd_ok       = pipe_read && !empty && !clear;
  assign pop         = rd_ok && (idx == LAST_IDX);
  assign drained_inc = drained + CNT_W'(1);
  assign target_hit  = (drain_target != '0) && (drained_inc == drain_target);

  always_ff @(posedge ti_clk or negedge reset_n) begin
    if (!reset_n) begin
      idx       <= '0;
      drained   <= '0;
      done      <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      idx       <= '0;
      drained   <= '0;
      done      <= 1'b0;
      underflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (pipe_read && empty) underflow <= 1'b1;
      if (rd_ok) idx <= idx + 1'b1;
      // A target lowered below the current count only fires again after wrap.
      if (pop) begin
        if (target_hit) begin
          drained <= '0;
          done    <= 1'b1;
        end else begin
          drained <= drained_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_block_serializer.sv
// Directed and random stimulus against a word-queue reference model with a negedge monitor.
module tb_pipe_block_serializer;

  logic        ti_clk = 1'b0;
  logic        reset_n;
  logic        clear;
  logic        blk_valid;
  logic        blk_ready;
  logic [63:0] blk_data;
  logic        pipe_read;
  logic [15:0] pipe_data;
  logic [15:0] drain_target;
  logic        done;
  logic [3:0]  level;
  logic        underflow;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] exp_words[$];
  logic [15:0] m_drained;
  logic        m_done;
  logic        m_under;

  pipe_block_serializer #(.DEPTH_LOG2(3), .CNT_W(16)) dut (
    .ti_clk       (ti_clk),
    .reset_n      (reset_n),
    .clear        (clear),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .blk_data     (blk_data),
    .pipe_read    (pipe_read),
    .pipe_data    (pipe_data),
    .drain_target (drain_target),
    .done         (done),
    .level        (level),
    .underflow    (underflow)
  );

  always #5 ti_clk = ~ti_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: FIFO contents as a flat queue of words; a block is stored while any of its words remain.
  always @(negedge ti_clk) begin
    int  s;
    int  blocks;
    logic nd;
    if (!reset_n) begin
      exp_words.delete();
      m_drained = '0;
      m_done    = 1'b0;
      m_under   = 1'b0;
    end else begin
      s      = exp_words.size();
      blocks = (s + 3) / 4;
      chk("pipe_data", pipe_data, (s == 0) ? 64'd0 : 64'(exp_words[0]));
      chk("level", level, 64'(blocks));
      chk("blk_ready", blk_ready, 64'(blocks != 8));
      chk("done", done, 64'(m_done));
      chk("underflow", underflow, 64'(m_under));
      if (clear) begin
        exp_words.delete();
        m_drained = '0;
        m_done    = 1'b0;
        m_under   = 1'b0;
      end else begin
        nd = 1'b0;
        if (pipe_read) begin
          if (s == 0) m_under = 1'b1;
          else begin
            if ((s % 4) == 1) begin
              if (drain_target != 0 && 16'(m_drained + 16'd1) == drain_target) begin
                nd = 1'b1;
                m_drained = '0;
              end else begin
                m_drained = m_drained + 16'd1;
              end
            end
            void'(exp_words.pop_front());
          end
        end
        if (blk_valid && blocks != 8) begin
          exp_words.push_back(blk_data[15:0]);
          exp_words.push_back(blk_data[31:16]);
          exp_words.push_back(blk_data[47:32]);
          exp_words.push_back(blk_data[63:48]);
        end
        m_done = nd;
      end
    end
  end

  task automatic step(input logic v, input logic [63:0] d, input logic r, input logic c);
    @(posedge ti_clk);
    #1;
    blk_valid = v;
    blk_data  = d;
    pipe_read = r;
    clear     = c;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic reads(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 64'd0, 1'b1, 1'b0);
  endtask

  task automatic pushes(input int n);
    for (int i = 0; i < n; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    step(1'b0, 64'd0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [63:0] held;
    reset_n      = 1'b0;
    clear        = 1'b0;
    blk_valid    = 1'b0;
    blk_data     = '0;
    pipe_read    = 1'b0;
    drain_target = '0;
    #12;
    chk("rst_pipe_data", pipe_data, 64'd0);
    chk("rst_blk_ready", blk_ready, 64'd1);
    chk("rst_level", level, 64'd0);
    @(posedge ti_clk);
    #1 reset_n = 1'b1;
    idle(2);

    // Word order of a single block
    step(1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
    reads(4);
    idle(2);

    // Fill beyond depth; ninth block held until a full block is read
    pushes(8);
    held = {$urandom, $urandom};
    for (int i = 0; i < 5; i++) step(1'b1, held, (i >= 1), 1'b0);
    step(1'b1, held, 1'b0, 1'b0);
    idle(1);
    reads(32);
    idle(2);

    // done with target 2, then disabled
    drain_target = 16'd2;
    do_clear();
    pushes(2);
    reads(8);
    idle(3);
    drain_target = 16'd0;
    do_clear();
    pushes(2);
    reads(8);
    idle(3);

    // Underflow is sticky and leaves the pointers alone
    reads(2);
    idle(1);
    pushes(1);
    reads(4);
    idle(1);
    do_clear();
    idle(1);

    // Full with simultaneous pop and valid: push waits one cycle
    pushes(8);
    reads(3);
    held = {$urandom, $urandom};
    step(1'b1, held, 1'b1, 1'b0);
    step(1'b1, held, 1'b0, 1'b0);
    idle(1);
    reads(32);
    idle(1);

    // Mid-block clear
    pushes(3);
    reads(2);
    do_clear();
    idle(1);
    pushes(1);
    reads(4);
    idle(1);

    // Asynchronous reset mid-transfer
    pushes(2);
    reads(2);
    @(posedge ti_clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_pipe_data", pipe_data, 64'd0);
    chk("arst_level", level, 64'd0);
    chk("arst_blk_ready", blk_ready, 64'd1);
    chk("arst_done", done, 64'd0);
    chk("arst_underflow", underflow, 64'd0);
    blk_valid = 1'b0;
    pipe_read = 1'b0;
    @(posedge ti_clk);
    @(posedge ti_clk);
    #1 reset_n = 1'b1;
    idle(1);

    // Random traffic, target reprogrammed only together with a clear
    drain_target = 16'($urandom_range(0, 4));
    do_clear();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        drain_target = 16'($urandom_range(0, 4));
        do_clear();
      end else begin
        step($urandom_range(0, 1) == 1, {$urandom, $urandom}, $urandom_range(0, 99) < 60, 1'b0);
      end
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
